// File: rtl/rst_seq_if.sv
// Reset-sequencer signal bundle: PLL lock input plus the reset/status outputs.
// master: sequencer side (samples locked, drives pll_rst/sys_rst_n/ready/lost_cnt).
// slave : PLL / system side (drives locked, observes the resets and status).
interface rst_seq_if;
    logic       locked;     // PLL lock flag, asynchronous to clkin
    logic       pll_rst;    // active-high reset to the PLL
    logic       sys_rst_n;  // active-low reset for PLL-clocked logic
    logic       ready;      // high while the sequencer is running
    logic [7:0] lost_cnt;   // saturating count of lock losses while running

    modport master (
        input  locked,
        output pll_rst,
        output sys_rst_n,
        output ready,
        output lost_cnt
    );

    modport slave (
        output locked,
        input  pll_rst,
        input  sys_rst_n,
        input  ready,
        input  lost_cnt
    );
endinterface

// File: rtl/rst_seq.sv
// PLL lock supervisor: holds system reset until lock has been stable HOLD_CYCLES, re-resets the PLL on lock timeout.
// Latency: release on edge N+HOLD_CYCLES+2 after lock is first sampled; loss drops sys_rst_n two edges after the sampled loss.
// Backpressure: none; locked is free-running, all outputs registered and reset asynchronously by rst_n.
// Ports: clkin (reference clock), rst_n (async active-low reset), bus (rst_seq_if.master: locked in; pll_rst, sys_rst_n, ready, lost_cnt out).
// Build option: define RST_SEQ_TIMEOUT_EN to enable the lock timeout and PLL re-reset pulse; undefined, S_WAIT waits forever.
module rst_seq #(
    parameter int HOLD_CYCLES   = 65536,
    parameter int LOCK_TIMEOUT  = 5000000,
    parameter int PLLRST_CYCLES = 16
) (
    input  logic         clkin,
    input  logic         rst_n,
    rst_seq_if.master    bus
);

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_HOLD   = 2'd1,
        S_RUN    = 2'd2,
        S_PLLRST = 2'd3
    } state_t;

    // Terminal counts, compared against the shared 24-bit counter.
    localparam logic [23:0] HOLD_LAST    = 24'(HOLD_CYCLES - 1);
    localparam logic [23:0] TIMEOUT_LAST = 24'(LOCK_TIMEOUT - 1);
    localparam logic [23:0] PLLRST_LAST  = 24'(PLLRST_CYCLES - 1);

`ifdef RST_SEQ_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    // Timeout path folds away: S_PLLRST can never be entered.
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    state_t      state;
    state_t      next;
    logic [23:0] cnt;
    logic        lock_m;
    logic        lock_s;

    logic        run_d;
    logic        pll_rst_d;
    logic        lost_inc;

    logic        sys_rst_n_q;
    logic        ready_q;
    logic        pll_rst_q;
    logic [7:0]  lost_cnt_q;

    // Two-flop synchronizer for the asynchronous lock flag; only lock_s is used.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= bus.locked;
            lock_s <= lock_m;
        end
    end

    // State register and shared counter; the counter restarts on every state change.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_WAIT;
            cnt   <= 24'd0;
        end else begin
            state <= next;
            if (next != state) begin
                cnt <= 24'd0;
            end else begin
                cnt <= cnt + 24'd1;
            end
        end
    end

    // Next-state logic.
    always_comb begin
        next = state;
        case (state)
            S_WAIT: begin
                // Lock wins over a simultaneous timeout.
                if (lock_s) begin
                    next = S_HOLD;
                end else if (TIMEOUT_EN && (cnt == TIMEOUT_LAST)) begin
                    next = S_PLLRST;
                end
            end
            S_HOLD: begin
                if (!lock_s) begin
                    next = S_WAIT;
                end else if (cnt == HOLD_LAST) begin
                    next = S_RUN;
                end
            end
            S_RUN: begin
                if (!lock_s) begin
                    next = S_WAIT;
                end
            end
            S_PLLRST: begin
                // Lock is meaningless while the PLL is held in reset.
                if (cnt == PLLRST_LAST) begin
                    next = S_WAIT;
                end
            end
            default: next = S_WAIT;
        endcase
    end

    // Output decode from next state, so the registered outputs track the state register.
    always_comb begin
        run_d     = (next == S_RUN);
        pll_rst_d = (next == S_PLLRST);
        lost_inc  = (state == S_RUN) && (next == S_WAIT) && (lost_cnt_q != 8'hFF);
    end

    // Output registers; pll_rst resets high so the PLL is held in reset with the board.
    always_ff @(posedge clkin or negedge rst_n) begin
        if (!rst_n) begin
            sys_rst_n_q <= 1'b0;
            ready_q     <= 1'b0;
            pll_rst_q   <= 1'b1;
            lost_cnt_q  <= 8'd0;
        end else begin
            sys_rst_n_q <= run_d;
            ready_q     <= run_d;
            pll_rst_q   <= pll_rst_d;
            if (lost_inc) begin
                lost_cnt_q <= lost_cnt_q + 8'd1;
            end
        end
    end

    assign bus.sys_rst_n = sys_rst_n_q;
    assign bus.ready     = ready_q;
    assign bus.pll_rst   = pll_rst_q;
    assign bus.lost_cnt  = lost_cnt_q;

endmodule

// File: tb/tb_rst_seq.sv
// Testbench for rst_seq: directed release/glitch/timeout/loss/reset scenarios plus randomized lock traffic.
// Expected outputs come from run-length and arithmetic rules on the sampled lock history.
// Ports: drives clkin, rst_n and rst_seq_if.locked; observes all interface outputs.
module tb_rst_seq;

    localparam int H  = 16;
    localparam int LT = 100;
    localparam int PR = 4;

`ifdef RST_SEQ_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clkin = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    rst_seq_if u_if ();

    rst_seq #(
        .HOLD_CYCLES   (H),
        .LOCK_TIMEOUT  (LT),
        .PLLRST_CYCLES (PR)
    ) dut (
        .clkin (clkin),
        .rst_n (rst_n),
        .bus   (u_if.master)
    );

    always #5 clkin = ~clkin;

    // Advance one edge; outputs are observed 1 time unit after it.
    task automatic tick();
        @(posedge clkin);
        #1;
        edge_n++;
    endtask

    // Release reset mid-cycle; the next rising edge is edge 1.
    task automatic release_rst();
        repeat (2) @(posedge clkin);
        #2;
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    task automatic do_reset();
        u_if.locked = 1'b0;
        #1;
        rst_n = 1'b0;
        release_rst();
    endtask

    task automatic test_reset();
        u_if.locked = 1'b0;
        @(posedge clkin);
        #3;
        rst_n = 1'b0;
        #1;
        checks++; if (u_if.pll_rst !== 1'b1)   begin errors++; $display("FAIL rst_pll_rst got %b want 1", u_if.pll_rst); end
        checks++; if (u_if.sys_rst_n !== 1'b0) begin errors++; $display("FAIL rst_sys_rst_n got %b want 0", u_if.sys_rst_n); end
        checks++; if (u_if.ready !== 1'b0)     begin errors++; $display("FAIL rst_ready got %b want 0", u_if.ready); end
        checks++; if (u_if.lost_cnt !== 8'd0)  begin errors++; $display("FAIL rst_lost_cnt got %0d want 0", u_if.lost_cnt); end
        release_rst();
        #1;
        checks++; if (u_if.pll_rst !== 1'b1)   begin errors++; $display("FAIL rst_pll_before_edge got %b want 1", u_if.pll_rst); end
        tick();
        checks++; if (u_if.pll_rst !== 1'b0)   begin errors++; $display("FAIL rst_pll_first_edge got %b want 0", u_if.pll_rst); end
        checks++; if (u_if.sys_rst_n !== 1'b0) begin errors++; $display("FAIL rst_sys_first_edge got %b want 0", u_if.sys_rst_n); end
    endtask

    // Lock first sampled on edge 10, stays high: release on edge 28.
    task automatic test_release();
        logic exp;
        do_reset();
        u_if.locked = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            tick();
            exp = (edge_n >= 10 + H + 2);
            checks++; if (u_if.ready !== exp)     begin errors++; $display("FAIL release_ready edge %0d got %b want %b", edge_n, u_if.ready, exp); end
            checks++; if (u_if.sys_rst_n !== exp) begin errors++; $display("FAIL release_sys edge %0d got %b want %b", edge_n, u_if.sys_rst_n, exp); end
            checks++; if (u_if.lost_cnt !== 8'd0) begin errors++; $display("FAIL release_lost edge %0d got %0d want 0", edge_n, u_if.lost_cnt); end
            u_if.locked = (edge_n + 1 >= 10);
        end
    endtask

    // High for 8 samples (edges 5..12), low on edge 13, high from edge 14: release 18 edges after the final rise.
    task automatic test_glitch();
        logic exp;
        do_reset();
        u_if.locked = 1'b0;
        for (int n = 1; n <= 45; n++) begin
            tick();
            exp = (edge_n >= 14 + H + 2);
            checks++; if (u_if.ready !== exp)     begin errors++; $display("FAIL glitch_ready edge %0d got %b want %b", edge_n, u_if.ready, exp); end
            checks++; if (u_if.lost_cnt !== 8'd0) begin errors++; $display("FAIL glitch_lost edge %0d got %0d want 0", edge_n, u_if.lost_cnt); end
            u_if.locked = ((edge_n + 1 >= 5) && (edge_n + 1 != 13));
        end
    endtask

    // Lock never arrives: PLL reset pulses of PR edges every LT+PR edges (only with the timeout build).
    task automatic test_timeout();
        logic exp;
        do_reset();
        u_if.locked = 1'b0;
        for (int n = 1; n <= 320; n++) begin
            tick();
            exp = TO_EN && (edge_n >= LT) && (((edge_n - LT) % (LT + PR)) < PR);
            checks++; if (u_if.pll_rst !== exp) begin errors++; $display("FAIL timeout_pll_rst edge %0d got %b want %b", edge_n, u_if.pll_rst, exp); end
            checks++; if (u_if.ready !== 1'b0)  begin errors++; $display("FAIL timeout_ready edge %0d got %b want 0", edge_n, u_if.ready); end
        end
    endtask

    // Random lock traffic. Running iff the sampled lock history ending two edges ago
    // holds at least H+1 consecutive ones; every fall of running is one lost lock.
    task automatic test_random();
        int   run_at [0:3000];
        int   remaining;
        int   exp_lost;
        logic cur;
        logic exp;
        logic prev;
        do_reset();
        run_at[0] = 0;
        remaining = 0;
        exp_lost  = 0;
        cur       = 1'b0;
        prev      = 1'b0;
        for (int n = 1; n <= 3000; n++) begin
            if (remaining == 0) begin
                cur       = ~cur;
                remaining = cur ? int'($urandom_range(40, 1)) : int'($urandom_range(30, 1));
            end
            u_if.locked = cur;
            remaining--;
            tick();
            run_at[n] = cur ? run_at[n-1] + 1 : 0;
            exp = (n >= 2) && (run_at[n-2] >= H + 1);
            if (prev && !exp) exp_lost = (exp_lost < 255) ? exp_lost + 1 : 255;
            prev = exp;
            checks++; if (u_if.ready !== exp)                begin errors++; $display("FAIL rand_ready edge %0d got %b want %b", edge_n, u_if.ready, exp); end
            checks++; if (u_if.sys_rst_n !== exp)            begin errors++; $display("FAIL rand_sys edge %0d got %b want %b", edge_n, u_if.sys_rst_n, exp); end
            checks++; if (u_if.lost_cnt !== 8'(exp_lost))    begin errors++; $display("FAIL rand_lost edge %0d got %0d want %0d", edge_n, u_if.lost_cnt, exp_lost); end
            checks++; if (u_if.pll_rst !== 1'b0)             begin errors++; $display("FAIL rand_pll_rst edge %0d got %b want 0", edge_n, u_if.pll_rst); end
        end
    endtask

    // 300 single-sample losses while running; lost_cnt saturates at 255.
    task automatic test_loss_saturate();
        int budget;
        int exp_lost;
        do_reset();
        u_if.locked = 1'b1;
        for (int i = 0; i < 300; i++) begin
            budget = 40;
            while (u_if.ready !== 1'b1 && budget > 0) begin
                tick();
                budget--;
            end
            checks++;
            if (u_if.ready !== 1'b1) begin
                errors++;
                $display("FAIL loss_reach_run iter %0d got %b want 1", i, u_if.ready);
                break;
            end
            u_if.locked = 1'b0;
            tick();                       // edge M samples the loss
            u_if.locked = 1'b1;
            checks++; if (u_if.sys_rst_n !== 1'b1) begin errors++; $display("FAIL loss_sys_m iter %0d got %b want 1", i, u_if.sys_rst_n); end
            tick();
            checks++; if (u_if.sys_rst_n !== 1'b1) begin errors++; $display("FAIL loss_sys_m1 iter %0d got %b want 1", i, u_if.sys_rst_n); end
            tick();
            exp_lost = (i + 1 < 255) ? i + 1 : 255;
            checks++; if (u_if.sys_rst_n !== 1'b0)         begin errors++; $display("FAIL loss_sys_m2 iter %0d got %b want 0", i, u_if.sys_rst_n); end
            checks++; if (u_if.lost_cnt !== 8'(exp_lost))  begin errors++; $display("FAIL loss_cnt iter %0d got %0d want %0d", i, u_if.lost_cnt, exp_lost); end
        end
    endtask

    // Asynchronous reset mid-hold (and mid PLL reset with the timeout build), then a clean restart.
    task automatic test_async_reset();
        int   budget;
        logic exp;
        do_reset();
        u_if.locked = 1'b1;
        budget = 40;
        while (u_if.ready !== 1'b1 && budget > 0) begin
            tick();
            budget--;
        end
        checks++; if (u_if.ready !== 1'b1) begin errors++; $display("FAIL async_pre_run got %b want 1", u_if.ready); end
        u_if.locked = 1'b0;
        tick();
        u_if.locked = 1'b1;
        tick();
        tick();
        checks++; if (u_if.lost_cnt !== 8'd1) begin errors++; $display("FAIL async_pre_lost got %0d want 1", u_if.lost_cnt); end
        repeat (8) tick();                // now part-way through the hold window
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (u_if.pll_rst !== 1'b1)   begin errors++; $display("FAIL async_hold_pll got %b want 1", u_if.pll_rst); end
        checks++; if (u_if.sys_rst_n !== 1'b0) begin errors++; $display("FAIL async_hold_sys got %b want 0", u_if.sys_rst_n); end
        checks++; if (u_if.ready !== 1'b0)     begin errors++; $display("FAIL async_hold_ready got %b want 0", u_if.ready); end
        checks++; if (u_if.lost_cnt !== 8'd0)  begin errors++; $display("FAIL async_hold_lost got %0d want 0", u_if.lost_cnt); end
        release_rst();
        for (int n = 1; n <= 25; n++) begin
            tick();
            exp = (edge_n >= 1 + H + 2);
            checks++; if (u_if.ready !== exp)    begin errors++; $display("FAIL async_resume_ready edge %0d got %b want %b", edge_n, u_if.ready, exp); end
            checks++; if (u_if.pll_rst !== 1'b0) begin errors++; $display("FAIL async_resume_pll edge %0d got %b want 0", edge_n, u_if.pll_rst); end
        end
`ifdef RST_SEQ_TIMEOUT_EN
        do_reset();
        u_if.locked = 1'b0;
        repeat (LT + 1) tick();
        checks++; if (u_if.pll_rst !== 1'b1) begin errors++; $display("FAIL async_pllrst_pre got %b want 1", u_if.pll_rst); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (u_if.pll_rst !== 1'b1)   begin errors++; $display("FAIL async_pllrst_pll got %b want 1", u_if.pll_rst); end
        checks++; if (u_if.sys_rst_n !== 1'b0) begin errors++; $display("FAIL async_pllrst_sys got %b want 0", u_if.sys_rst_n); end
        release_rst();
        for (int n = 1; n <= LT + PR + 2; n++) begin
            tick();
            exp = (edge_n >= LT) && (edge_n < LT + PR);
            checks++; if (u_if.pll_rst !== exp) begin errors++; $display("FAIL async_pllrst_resume edge %0d got %b want %b", edge_n, u_if.pll_rst, exp); end
        end
`endif
    endtask

    initial begin
        u_if.locked = 1'b0;
        rst_n       = 1'b0;
        test_reset();
        test_release();
        test_glitch();
        test_timeout();
        test_random();
        test_loss_saturate();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 The block SHALL take one clock and an asynchronous, active-low reset: clkin (50 MHz board reference, same net that feeds the PLL refclk) and rst_n.
REQ-002 Parameter HOLD_CYCLES, default 65536: cycles lock must stay stable before release of system reset; range 1..2^24-1.
REQ-003 Parameter LOCK_TIMEOUT, default 5000000: cycles allowed in S_WAIT before the PLL is re-reset; range 1..2^24-1.
REQ-004 Parameter PLLRST_CYCLES, default 16: width of the PLL reset pulse; range 1..2^24-1.
REQ-005 Port: clkin  in  1  reference clock, all logic on rising edge.
REQ-006 Port: rst_n  in  1  async active-low reset (board button / power-on).
REQ-007 Port: locked  in  1  PLL lock flag, asynchronous to clkin.
REQ-008 Port: pll_rst  out  1  active-high reset to the PLL rst input.
REQ-009 Port: sys_rst_n  out  1  active-low system reset for PLL-clocked logic; asserted async, deasserted on clkin edge.
REQ-010 Port: ready  out  1  high while the FSM is in S_RUN.
REQ-011 Port: lost_cnt  out  8  count of lock losses seen in S_RUN, saturating.

Function
REQ-012 locked SHALL pass through a 2-flop synchronizer; FSM uses only the second stage (lock_s).
REQ-013 FSM states: S_WAIT, S_HOLD, S_RUN, S_PLLRST; one shared 24-bit counter cnt, cleared on every state change.
REQ-014 S_WAIT: cnt increments; lock_s=1 -> S_HOLD; else cnt==LOCK_TIMEOUT-1 -> S_PLLRST (macro-enabled only); lock_s=1 wins on simultaneous timeout.
REQ-015 S_HOLD: lock_s=0 -> S_WAIT (glitch, no lost_cnt change); cnt==HOLD_CYCLES-1 with lock_s=1 -> S_RUN.
REQ-016 S_RUN: lock_s=0 -> S_WAIT and lost_cnt+1, holding at 255.
REQ-017 S_PLLRST: lock_s ignored; cnt==PLLRST_CYCLES-1 -> S_WAIT.
REQ-018 All outputs SHALL be registered from next-state: sys_rst_n=ready=(next==S_RUN); pll_rst=(next==S_PLLRST).
REQ-019 Release latency: if edge N is first to sample locked=1 and locked stays high, sys_rst_n and ready SHALL rise on edge N+HOLD_CYCLES+2.
REQ-020 Loss latency: if edge M first samples locked=0 in S_RUN, sys_rst_n SHALL fall on edge M+2.
REQ-021 pll_rst SHALL be high for exactly PLLRST_CYCLES consecutive cycles per timeout event.

Reset
REQ-022 rst_n low SHALL asynchronously force: state S_WAIT, cnt=0, sync flops 0, sys_rst_n=0, ready=0, lost_cnt=0, pll_rst=1.
REQ-023 pll_rst SHALL drop on the first clkin edge after rst_n rises; reset asserted mid-operation in any state SHALL give REQ-022 values immediately.

Configuration
REQ-024 Macro RST_SEQ_TIMEOUT_EN defined: S_PLLRST and LOCK_TIMEOUT/PLLRST_CYCLES logic present per REQ-014/017/021.
REQ-025 Macro undefined: S_PLLRST unreachable, S_WAIT waits indefinitely, pll_rst is 0 except while rst_n low / before first post-reset edge.

Verification (HOLD_CYCLES=16, LOCK_TIMEOUT=100, PLLRST_CYCLES=4, macro defined unless stated)
REQ-026 Release rst_n, raise locked at edge 10 -> sys_rst_n and ready high at edge 28, lost_cnt=0.
REQ-027 locked high 8 cycles then low 1 cycle then high -> no release until 18 edges after final rise; lost_cnt=0.
REQ-028 locked never rises -> pll_rst high edges 100..103 after reset release, repeating every 104 cycles; macro undefined -> pll_rst stays 0.
REQ-029 In S_RUN drop locked 300 times -> sys_rst_n falls 2 edges after each sampled loss; lost_cnt saturates at 255.
REQ-030 Assert rst_n mid S_HOLD and mid S_PLLRST -> outputs at REQ-022 values without a clock edge; normal sequence resumes after release.
